// File: rtl/pic_int_sequencer.sv
// Interrupt sequencing core of an 8259A-style PIC. It latches IR requests,
// resolves rotating fully-nested priority against the ISR, and runs the INTA handshake.
module pic_int_sequencer #(
    parameter bit         LEVEL_TRIG = 1'b0,
    parameter logic [4:0] VEC_BASE   = 5'b00001
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] ir,
    input  logic [7:0] imr,
    input  logic       inta_n,
    input  logic       eoi,
    input  logic       seoi,
    input  logic [2:0] seoi_lvl,
    input  logic       rot_eoi,
    output logic       int_out,
    output logic [7:0] vector,
    output logic       vector_valid,
    output logic [7:0] irr,
    output logic [7:0] isr
);

    typedef enum logic [1:0] {IDLE, PEND, ACK1, ACK2} state_t;

    state_t     state, state_nxt;
    logic [7:0] ir_d;
    logic       inta_d, ack1_seen, spurious;
    logic [2:0] lowest_prio, level;
    logic       int_nxt, vv_nxt, freeze;
    logic [7:0] vector_nxt;
    logic [3:0] req_hi, isr_hi;
    logic       cand;
    logic [2:0] cand_lvl;
    logic       inta_fall, inta_rise;
    logic [7:0] ack_clr, eoi_clr, irr_nxt, isr_nxt;

    // {found, level} of the highest-priority set bit; scan order starts at lp+1 and wraps
    function automatic logic [3:0] pick_hi(input logic [7:0] v, input logic [2:0] lp);
        logic [3:0] r;
        logic [2:0] l;
        r = 4'b0;
        for (int k = 7; k >= 0; k--) begin
            l = lp + 3'd1 + 3'(k);
            if (v[l]) r = {1'b1, l};
        end
        return r;
    endfunction

    function automatic logic [2:0] rank(input logic [2:0] l, input logic [2:0] lp);
        return l - lp - 3'd1;
    endfunction

    always_comb begin
        req_hi   = pick_hi(irr & ~imr, lowest_prio);
        isr_hi   = pick_hi(isr, lowest_prio);
        cand_lvl = req_hi[2:0];
        cand     = req_hi[3] && (!isr_hi[3] ||
                   (rank(req_hi[2:0], lowest_prio) < rank(isr_hi[2:0], lowest_prio)));
    end

    assign inta_fall = inta_d & ~inta_n;
    assign inta_rise = ~inta_d & inta_n;

    always_comb begin
        state_nxt  = state;
        int_nxt    = int_out;
        vv_nxt     = vector_valid;
        vector_nxt = vector;
        freeze     = 1'b0;
        case (state)
            IDLE: begin
                if (cand) begin
                    state_nxt = PEND;
                    int_nxt   = 1'b1;
                end
            end
            // An INTA edge commits the handshake even if the request vanished meanwhile
            PEND: begin
                if (inta_fall) begin
                    state_nxt = ACK1;
                    int_nxt   = 1'b0;
                end else if (!cand) begin
                    state_nxt = IDLE;
                    int_nxt   = 1'b0;
                end
            end
            ACK1: begin
                if (!ack1_seen) begin
                    freeze = 1'b1;
                end else if (inta_fall) begin
                    state_nxt  = ACK2;
                    vv_nxt     = 1'b1;
                    vector_nxt = {VEC_BASE, spurious ? 3'd7 : level};
                end
            end
            ACK2: begin
                if (inta_rise) begin
                    state_nxt = IDLE;
                    vv_nxt    = 1'b0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Acknowledge set is OR-ed last so it wins over a same-cycle EOI of that bit
    always_comb begin
        ack_clr = 8'h00;
        if (freeze && cand) ack_clr[cand_lvl] = 1'b1;
        if (LEVEL_TRIG) irr_nxt = ir & ~ack_clr;
        else            irr_nxt = (irr & ~ack_clr) | (ir & ~ir_d);
        eoi_clr = 8'h00;
        if (seoi)                   eoi_clr[seoi_lvl]    = 1'b1;
        else if (eoi && isr_hi[3])  eoi_clr[isr_hi[2:0]] = 1'b1;
        isr_nxt = (isr & ~eoi_clr) | ack_clr;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            irr          <= 8'h00;
            isr          <= 8'h00;
            ir_d         <= 8'h00;
            inta_d       <= 1'b1;
            ack1_seen    <= 1'b0;
            spurious     <= 1'b0;
            lowest_prio  <= 3'd7;
            level        <= 3'd0;
            int_out      <= 1'b0;
            vector       <= 8'h00;
            vector_valid <= 1'b0;
        end else begin
            state        <= state_nxt;
            irr          <= irr_nxt;
            isr          <= isr_nxt;
            ir_d         <= ir;
            inta_d       <= inta_n;
            ack1_seen    <= (state == ACK1);
            int_out      <= int_nxt;
            vector       <= vector_nxt;
            vector_valid <= vv_nxt;
            if (freeze) begin
                level    <= cand ? cand_lvl : 3'd7;
                spurious <= !cand;
            end
            if (!seoi && eoi && rot_eoi && isr_hi[3]) lowest_prio <= isr_hi[2:0];
        end
    end

endmodule
